// File: rtl/sid_envelope.sv
// SID voice envelope generator: ADSR rate counter, exponential
// decay shaping and 8-bit envelope level for the envelope DAC.
module sid_envelope #(
    parameter int ADSR_BUG = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       gate,
    input  logic [3:0] attack,
    input  logic [3:0] decay,
    input  logic [3:0] sustain,
    input  logic [3:0] release_,
    output logic [7:0] env,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ATTACK  = 2'd0,
        ST_DECAY   = 2'd1,
        ST_RELEASE = 2'd2
    } st_t;

    st_t         st_q, st_d, st_eff;
    logic        gate_q;
    logic [14:0] rate_q, rate_d, rate_base, rate_inc;
    logic [14:0] per_q, period;
    logic [4:0]  exp_q, exp_d, exp_inc;
    logic [4:0]  eper_q, eper_d;
    logic [7:0]  env_d;
    logic [3:0]  nib;
    logic        rise, fall, tick, frozen, step;

    assign state = st_q;

    function automatic logic [14:0] rate_period(input logic [3:0] n);
        logic [14:0] p;
        case (n)
            4'd0:    p = 15'd9;
            4'd1:    p = 15'd32;
            4'd2:    p = 15'd63;
            4'd3:    p = 15'd95;
            4'd4:    p = 15'd149;
            4'd5:    p = 15'd220;
            4'd6:    p = 15'd267;
            4'd7:    p = 15'd313;
            4'd8:    p = 15'd392;
            4'd9:    p = 15'd977;
            4'd10:   p = 15'd1954;
            4'd11:   p = 15'd3126;
            4'd12:   p = 15'd3907;
            4'd13:   p = 15'd11720;
            4'd14:   p = 15'd19532;
            default: p = 15'd31251;
        endcase
        return p;
    endfunction

    always_comb begin
        rise   = gate & ~gate_q;
        fall   = ~gate & gate_q;
        st_eff = st_q;
        if (rise)
            st_eff = ST_ATTACK;
        else if (fall)
            st_eff = ST_RELEASE;

        unique case (st_eff)
            ST_ATTACK: nib = attack;
            ST_DECAY:  nib = decay;
            default:   nib = release_;
        endcase
        period = rate_period(nib);

        // Without the bug the count restarts whenever the period moves
        rate_base = rate_q;
        if (ADSR_BUG == 0 && period != per_q)
            rate_base = 15'd0;
        rate_inc = rate_base + 15'd1;
        tick     = (rate_inc == period);
        rate_d   = tick ? 15'd0 : rate_inc;

        frozen  = (st_eff != ST_ATTACK) && (env == 8'h00);
        exp_inc = exp_q + 5'd1;
        exp_d   = exp_q;
        step    = 1'b0;
        if (tick && !frozen) begin
            if (st_eff == ST_ATTACK)
                step = 1'b1;
            else
                step = (exp_inc == eper_q);
            exp_d = (step || st_eff == ST_ATTACK) ? 5'd0 : exp_inc;
        end

        env_d = env;
        st_d  = st_eff;
        if (step) begin
            unique case (st_eff)
                ST_ATTACK: begin
                    if (env != 8'hFF)
                        env_d = env + 8'd1;
                    if (env_d == 8'hFF)
                        st_d = ST_DECAY;
                end
                ST_DECAY: begin
                    if (env != {sustain, sustain})
                        env_d = env - 8'd1;
                end
                default: env_d = env - 8'd1;
            endcase
        end

        // Exponential slow-down tracks the level just reached
        eper_d = eper_q;
        if (env_d != env) begin
            unique case (env_d)
                8'hFF:   eper_d = 5'd1;
                8'h5D:   eper_d = 5'd2;
                8'h36:   eper_d = 5'd4;
                8'h1A:   eper_d = 5'd8;
                8'h0E:   eper_d = 5'd16;
                8'h06:   eper_d = 5'd30;
                8'h00:   eper_d = 5'd1;
                default: eper_d = eper_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            env    <= 8'h00;
            st_q   <= ST_RELEASE;
            rate_q <= 15'd0;
            per_q  <= 15'd0;
            exp_q  <= 5'd0;
            eper_q <= 5'd1;
            gate_q <= 1'b0;
        end else if (ce) begin
            env    <= env_d;
            st_q   <= st_d;
            rate_q <= rate_d;
            per_q  <= period;
            exp_q  <= exp_d;
            eper_q <= eper_d;
            gate_q <= gate;
        end
    end

endmodule

// File: tb/tb_sid_envelope.sv
// Randomised scoreboard bench for sid_envelope against an
// arithmetic reference model of the ADSR rules.
module tb_sid_envelope;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       gate = 1'b0;
    logic [3:0] attack = 4'd0;
    logic [3:0] decay = 4'd0;
    logic [3:0] sustain = 4'd0;
    logic [3:0] release_ = 4'd0;
    logic [7:0] env;
    logic [1:0] state;

    sid_envelope dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .gate(gate),
        .attack(attack),
        .decay(decay),
        .sustain(sustain),
        .release_(release_),
        .env(env),
        .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    bit         n_reset = 1'b1;
    bit         n_gate = 1'b0;
    logic [3:0] n_a = 4'd0;
    logic [3:0] n_d = 4'd0;
    logic [3:0] n_s = 4'd0;
    logic [3:0] n_r = 4'd0;

    int per_tbl[16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                        392, 977, 1954, 3126, 3907, 11720,
                        19532, 31251};
    int thr_env[7] = '{255, 93, 54, 26, 14, 6, 0};
    int thr_per[7] = '{1, 2, 4, 8, 16, 30, 1};

    int m_env, m_st, m_cnt, m_exp, m_eper;
    bit m_gate;

    task automatic m_reset();
        m_env  = 0;
        m_st   = 2;
        m_cnt  = 0;
        m_exp  = 0;
        m_eper = 1;
        m_gate = 0;
    endtask

    task automatic m_ce(input bit g, input int a, input int d,
                        input int s, input int r);
        int per, old;
        bit tick;
        if (g && !m_gate)
            m_st = 0;
        else if (!g && m_gate)
            m_st = 2;
        m_gate = g;
        per = per_tbl[(m_st == 0) ? a : (m_st == 1) ? d : r];
        m_cnt = (m_cnt + 1) % 32768;
        tick = (m_cnt == per);
        if (tick)
            m_cnt = 0;
        if (!tick || (m_st != 0 && m_env == 0))
            return;
        old = m_env;
        if (m_st == 0) begin
            m_exp = 0;
            if (m_env < 255)
                m_env++;
            if (m_env == 255)
                m_st = 1;
        end else begin
            m_exp++;
            if (m_exp != m_eper)
                return;
            m_exp = 0;
            if (m_st == 2 || m_env != 17 * s)
                m_env--;
        end
        if (m_env != old)
            foreach (thr_env[i])
                if (m_env == thr_env[i])
                    m_eper = thr_per[i];
    endtask

    task automatic push_exp();
        logic [9:0] e;
        e = {8'(m_env), 2'(m_st)};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit cev);
        @(negedge clk);
        reset    = n_reset;
        ce       = cev;
        gate     = n_gate;
        attack   = n_a;
        decay    = n_d;
        sustain  = n_s;
        release_ = n_r;
        if (n_reset)
            m_reset();
        else if (cev)
            m_ce(n_gate, n_a, n_d, n_s, n_r);
        push_exp();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1);
    endtask

    task automatic chk(input string nm, input int got,
                       input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d",
                     nm, got, want);
        end
    endtask

    task automatic peek(input string nm, input int e_env,
                        input int e_st);
        @(posedge clk);
        #3;
        chk({nm, "_env"}, int'(env), e_env);
        chk({nm, "_state"}, int'(state), e_st);
    endtask

    task automatic run_until(input int target, input int bound);
        int n;
        n = 0;
        while (m_env != target && n < bound) begin
            cyc(1'b1);
            n++;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #3;
        reset   = 1'b1;
        ce      = 1'b1;
        n_reset = 1'b1;
        m_reset();
        push_exp();
        #1;
        chk("async_rst_env", int'(env), 0);
        chk("async_rst_state", int'(state), 2);
    endtask

    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({env, state} !== e) begin
                    errors++;
                    $display("FAIL sb t=%0t env %0h st %0d exp env %0h st %0d",
                             $time, env, state, e[9:2], e[1:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        m_reset();
        n_s = 4'hA;
        cyc(1'b0);
        cyc(1'b1);
        peek("reset", 0, 2);

        // attack at nibble 0 with gate held from reset release
        n_reset = 1'b0;
        n_gate  = 1'b1;
        run(9);
        peek("att9", 1, 0);
        run(2286);
        peek("att_full", 255, 1);

        // decay to sustain 0xAA, then long hold
        run(765);
        peek("sus_reach", 170, 1);
        run(10000);
        peek("sus_hold", 170, 1);

        // release with exponential slow-down to frozen zero
        n_gate = 1'b0;
        run(7000);
        peek("rel_zero", 0, 2);
        run(50);
        peek("zero_frz", 0, 2);

        // gate rise mid-release resumes from current level
        n_gate = 1'b1;
        run_until(80, 2000);
        peek("up_to_50", 80, 0);
        n_gate = 1'b0;
        run_until(64, 2000);
        peek("down_to_40", 64, 2);
        n_gate = 1'b1;
        cyc(1'b1);
        peek("rerise", m_env, 0);
        chk("no_drop", int'(env >= 8'h40), 1);
        run(100);

        // rate counter wrap when the period shrinks below the count
        n_reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        n_reset = 1'b0;
        n_a = 4'hF;
        run(500);
        n_a = 4'h0;
        run(32276);
        peek("wrap_wait", 0, 0);
        run(1);
        peek("wrap_tick", 1, 0);
        run(9);
        peek("wrap_next", 2, 0);

        // async reset mid-attack, ce pulses while held
        run_until(128, 1500);
        peek("pre_rst", 128, 0);
        async_reset();
        run(3);
        peek("rst_hold", 0, 2);
        n_reset = 1'b0;
        cyc(1'b1);
        peek("rst_rise", 0, 0);

        // random traffic
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0)
                n_gate = ~n_gate;
            if ($urandom_range(0, 499) == 0) begin
                n_a = 4'($urandom_range(0, 2));
                n_d = 4'($urandom_range(0, 2));
                n_r = 4'($urandom_range(0, 2));
                n_s = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3999) == 0) begin
                async_reset();
                n_reset = 1'b0;
            end else begin
                cyc($urandom_range(0, 2) != 0);
            end
        end

        repeat (3) @(posedge clk);
        #4;
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
